// File: rtl/microondas_controle_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : microondas_controle_if                                    |
// | Purpose  : Front-panel bundle between the microwave controller and   |
// |            its keypad, buttons, door switch, display and magnetron.  |
// | Signals  : teclado[9:0]   one-hot keypad, bit k = digit k            |
// |            startn/stopn/clrn  active-low buttons (levels)            |
// |            porta_fechada  1 = door closed                            |
// |            bcd_min/bcd_dez/bcd_uni  M:SS cook time in BCD            |
// |            ligar  magnetron enable, bip  end-of-cycle alarm          |
// |            estado  IDLE=0 COOK=1 PAUSE=2 DONE=3                      |
// | Modports : master drives the panel inputs, slave is the controller. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface microondas_controle_if;
  logic [9:0] teclado;
  logic       startn;
  logic       stopn;
  logic       clrn;
  logic       porta_fechada;
  logic [3:0] bcd_min;
  logic [3:0] bcd_dez;
  logic [3:0] bcd_uni;
  logic       ligar;
  logic       bip;
  logic [1:0] estado;

  modport master (
    output teclado, startn, stopn, clrn, porta_fechada,
    input  bcd_min, bcd_dez, bcd_uni, ligar, bip, estado
  );

  modport slave (
    input  teclado, startn, stopn, clrn, porta_fechada,
    output bcd_min, bcd_dez, bcd_uni, ligar, bip, estado
  );
endinterface
`default_nettype wire

// File: rtl/microondas_controle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : microondas_controle                                       |
// | Purpose  : Cooking-cycle controller. Collects the M:SS time from the |
// |            keypad, runs the 1 Hz countdown, drives the magnetron     |
// |            enable and the end-of-cycle alarm.                        |
// | Ports    : clk100Hz  system clock, rising edge                       |
// |            rst       synchronous active-high reset                   |
// |            ctl       microondas_controle_if.slave (panel bundle)     |
// | Params   : PRESCALE     clock cycles per countdown second            |
// |            DONE_CYCLES  cycles the alarm sounds before IDLE          |
// | Options  : QUICK_START_EN - start at 0:00 loads 0:30, start while    |
// |            cooking adds 30 s (saturating at 9:59).                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module microondas_controle #(
  parameter int PRESCALE    = 100,
  parameter int DONE_CYCLES = 300
) (
  input  wire logic             clk100Hz,
  input  wire logic             rst,
  microondas_controle_if.slave  ctl
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DONE_LAST  = DW'(DONE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [3:0]    min_q, dez_q, uni_q;
  logic [PW-1:0] presc_q;
  logic [DW-1:0] done_cnt_q;
  logic          ligar_q, bip_q;
  logic          key_prev_q, startn_prev_q, stopn_prev_q;

  // Button / key edge detection
  logic       start_edge, stop_edge;
  logic       key_any, key_edge, key_onehot, key_ok;
  logic [3:0] key_val;

  assign start_edge = startn_prev_q & ~ctl.startn;
  assign stop_edge  = stopn_prev_q  & ~ctl.stopn;
  assign key_any    = |ctl.teclado;
  assign key_edge   = key_any & ~key_prev_q;
  // x & (x-1) clears the lowest set bit: zero means at most one bit set
  assign key_onehot = key_any & ((ctl.teclado & (ctl.teclado - 10'd1)) == 10'd0);
  // A key shifted in makes the old seconds digit the new tens digit,
  // which must stay within 0-5
  assign key_ok     = key_edge & key_onehot & (uni_q <= 4'd5);

  always_comb begin
    key_val = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (ctl.teclado[k]) key_val = 4'(k);
    end
  end

  // Countdown helpers
  logic       time_zero, last_sec, tick;
  logic [3:0] dec_min, dec_dez, dec_uni;

  assign time_zero = (min_q == 4'd0) && (dez_q == 4'd0) && (uni_q == 4'd0);
  assign last_sec  = (min_q == 4'd0) && (dez_q == 4'd0) && (uni_q == 4'd1);
  assign tick      = (presc_q == PRESC_LAST);

  always_comb begin
    dec_min = min_q;
    dec_dez = dez_q;
    dec_uni = uni_q;
    if (uni_q != 4'd0) begin
      dec_uni = uni_q - 4'd1;
    end else if (dez_q != 4'd0) begin
      dec_dez = dez_q - 4'd1;
      dec_uni = 4'd9;
    end else begin
      dec_min = min_q - 4'd1;
      dec_dez = 4'd5;
      dec_uni = 4'd9;
    end
  end

`ifdef QUICK_START_EN
  // +30 s in BCD: tens digit carries into minutes past 5; a carry out of
  // the minutes digit pins the time at 9:59
  logic [3:0] add_min, add_dez, add_uni;

  always_comb begin
    add_min = min_q;
    add_dez = dez_q + 4'd3;
    add_uni = uni_q;
    if (dez_q >= 4'd3) begin
      if (min_q == 4'd9) begin
        add_min = 4'd9;
        add_dez = 4'd5;
        add_uni = 4'd9;
      end else begin
        add_min = min_q + 4'd1;
        add_dez = dez_q - 4'd3;
      end
    end
  end
`endif

  always_ff @(posedge clk100Hz) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      min_q         <= 4'd0;
      dez_q         <= 4'd0;
      uni_q         <= 4'd0;
      presc_q       <= '0;
      done_cnt_q    <= '0;
      ligar_q       <= 1'b0;
      bip_q         <= 1'b0;
      key_prev_q    <= 1'b0;
      startn_prev_q <= 1'b1;
      stopn_prev_q  <= 1'b1;
    end else begin
      key_prev_q    <= key_any;
      startn_prev_q <= ctl.startn;
      stopn_prev_q  <= ctl.stopn;

      if (!ctl.clrn) begin
        state_q    <= ST_IDLE;
        min_q      <= 4'd0;
        dez_q      <= 4'd0;
        uni_q      <= 4'd0;
        presc_q    <= '0;
        done_cnt_q <= '0;
        ligar_q    <= 1'b0;
        bip_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (stop_edge) begin
              min_q <= 4'd0;
              dez_q <= 4'd0;
              uni_q <= 4'd0;
            end else if (start_edge) begin
              // Any start edge consumes the cycle, even when refused
              if (ctl.porta_fechada && !time_zero) begin
                state_q <= ST_COOK;
                presc_q <= '0;
                ligar_q <= 1'b1;
              end
`ifdef QUICK_START_EN
              else if (ctl.porta_fechada) begin
                min_q   <= 4'd0;
                dez_q   <= 4'd3;
                uni_q   <= 4'd0;
                state_q <= ST_COOK;
                presc_q <= '0;
                ligar_q <= 1'b1;
              end
`endif
            end else if (key_ok) begin
              min_q <= dez_q;
              dez_q <= uni_q;
              uni_q <= key_val;
            end
          end

          ST_COOK: begin
            if (!ctl.porta_fechada || stop_edge) begin
              // Prescaler is left as is so the second resumes mid-way
              state_q <= ST_PAUSE;
              ligar_q <= 1'b0;
            end
`ifdef QUICK_START_EN
            else if (start_edge) begin
              min_q <= add_min;
              dez_q <= add_dez;
              uni_q <= add_uni;
            end
`endif
            else if (tick) begin
              presc_q <= '0;
              min_q   <= dec_min;
              dez_q   <= dec_dez;
              uni_q   <= dec_uni;
              if (last_sec) begin
                state_q    <= ST_DONE;
                ligar_q    <= 1'b0;
                bip_q      <= 1'b1;
                done_cnt_q <= '0;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end

          ST_PAUSE: begin
            if (stop_edge) begin
              state_q <= ST_IDLE;
              min_q   <= 4'd0;
              dez_q   <= 4'd0;
              uni_q   <= 4'd0;
            end else if (start_edge && ctl.porta_fechada) begin
              state_q <= ST_COOK;
              ligar_q <= 1'b1;
            end
          end

          ST_DONE: begin
            if (stop_edge || !ctl.porta_fechada || (done_cnt_q == DONE_LAST)) begin
              state_q    <= ST_IDLE;
              bip_q      <= 1'b0;
              done_cnt_q <= '0;
            end else begin
              done_cnt_q <= done_cnt_q + 1'b1;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            ligar_q <= 1'b0;
            bip_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ctl.bcd_min = min_q;
  assign ctl.bcd_dez = dez_q;
  assign ctl.bcd_uni = uni_q;
  assign ctl.ligar   = ligar_q;
  assign ctl.bip     = bip_q;
  assign ctl.estado  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_microondas_controle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_microondas_controle                                    |
// | Purpose  : Self-checking bench for microondas_controle with          |
// |            PRESCALE=4, DONE_CYCLES=8. Directed scenarios followed by |
// |            random panel activity, all compared every cycle against  |
// |            a seconds-based reference model.                          |
// | Options  : QUICK_START_EN selects the quick-start expectations.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_microondas_controle;

  localparam int PRESCALE    = 4;
  localparam int DONE_CYCLES = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  microondas_controle_if ctl();

  microondas_controle #(
    .PRESCALE    (PRESCALE),
    .DONE_CYCLES (DONE_CYCLES)
  ) dut (
    .clk100Hz (clk),
    .rst      (rst),
    .ctl      (ctl)
  );

  always #5 clk = ~clk;

  // Reference model: cook time held as plain seconds
  int m_state = 0;   // 0 idle, 1 cook, 2 pause, 3 done
  int m_secs  = 0;
  int m_presc = 0;
  int m_done  = 0;
  bit m_ligar = 0, m_bip = 0;
  bit m_kprev = 0, m_sprev = 1, m_tprev = 1;

  task automatic model_step();
    bit se, te, ke, one;
    int k, d, u;
    if (rst) begin
      m_state = 0; m_secs = 0; m_presc = 0; m_done = 0;
      m_ligar = 0; m_bip = 0;
      m_kprev = 0; m_sprev = 1; m_tprev = 1;
      return;
    end
    se  = m_sprev && !ctl.startn;
    te  = m_tprev && !ctl.stopn;
    ke  = (ctl.teclado != 10'd0) && !m_kprev;
    one = ($countones(ctl.teclado) == 1);
    k = 0;
    for (int i = 0; i < 10; i++) if (ctl.teclado[i]) k = i;
    m_sprev = ctl.startn;
    m_tprev = ctl.stopn;
    m_kprev = (ctl.teclado != 10'd0);
    d = (m_secs % 60) / 10;
    u = m_secs % 10;

    if (!ctl.clrn) begin
      m_state = 0; m_secs = 0; m_presc = 0; m_done = 0;
      m_ligar = 0; m_bip = 0;
    end else begin
      case (m_state)
        0: begin
          if (te) m_secs = 0;
          else if (se) begin
            if (ctl.porta_fechada && m_secs != 0) begin
              m_state = 1; m_presc = 0; m_ligar = 1;
            end
`ifdef QUICK_START_EN
            else if (ctl.porta_fechada) begin
              m_secs = 30; m_state = 1; m_presc = 0; m_ligar = 1;
            end
`endif
          end else if (ke && one && u <= 5) begin
            m_secs = d * 60 + u * 10 + k;
          end
        end
        1: begin
          if (!ctl.porta_fechada || te) begin
            m_state = 2; m_ligar = 0;
          end
`ifdef QUICK_START_EN
          else if (se) begin
            m_secs = (m_secs + 30 > 599) ? 599 : m_secs + 30;
          end
`endif
          else if (m_presc == PRESCALE - 1) begin
            m_presc = 0;
            m_secs  = m_secs - 1;
            if (m_secs == 0) begin
              m_state = 3; m_ligar = 0; m_bip = 1; m_done = 0;
            end
          end else begin
            m_presc = m_presc + 1;
          end
        end
        2: begin
          if (te) begin
            m_state = 0; m_secs = 0;
          end else if (se && ctl.porta_fechada) begin
            m_state = 1; m_ligar = 1;
          end
        end
        default: begin
          if (te || !ctl.porta_fechada || m_done == DONE_CYCLES - 1) begin
            m_state = 0; m_bip = 0; m_done = 0;
          end else begin
            m_done = m_done + 1;
          end
        end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {ctl.estado, ctl.bcd_min, ctl.bcd_dez, ctl.bcd_uni, ctl.ligar, ctl.bip};
  endfunction

  function automatic logic [15:0] dut_time();
    return {4'h0, ctl.bcd_min, ctl.bcd_dez, ctl.bcd_uni};
  endfunction

  function automatic logic [15:0] mk(input int st, input logic [11:0] t, input bit lg, input bit bp);
    return {2'(st), t, lg, bp};
  endfunction

  // One clock edge, model update, then a full-output comparison
  task automatic cyc();
    logic [15:0] expv;
    @(posedge clk);
    model_step();
    #1;
    expv = {2'(m_state), 4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10),
            m_ligar, m_bip};
    chk("cycle", dut_vec(), expv);
  endtask

  task automatic press(input int k);
    ctl.teclado = 10'(1 << k);
    cyc();
    ctl.teclado = 10'd0;
    cyc();
  endtask

  task automatic start_pulse();
    ctl.startn = 1'b0;
    cyc();
    ctl.startn = 1'b1;
  endtask

  initial begin
    int r;
    ctl.teclado = 10'd0;
    ctl.startn = 1'b1;
    ctl.stopn = 1'b1;
    ctl.clrn = 1'b1;
    ctl.porta_fechada = 1'b1;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("reset_state", dut_vec(), 16'h0000);

    // 1: 0:14 full cycle with start held
    press(1);
    press(4);
    chk("t1_digits", dut_time(), 16'h0014);
    ctl.startn = 1'b0;
    cyc();
    chk("t1_cook", dut_vec(), mk(1, 12'h014, 1, 0));
    repeat (55) cyc();
    chk("t1_last_sec", dut_vec(), mk(1, 12'h001, 1, 0));
    cyc();
    chk("t1_done", dut_vec(), mk(3, 12'h000, 0, 1));
    repeat (7) cyc();
    chk("t1_bip_end", dut_vec(), mk(3, 12'h000, 0, 1));
    cyc();
    chk("t1_idle", dut_vec(), mk(0, 12'h000, 0, 0));
    repeat (5) cyc();
    chk("t1_held_start", dut_vec(), mk(0, 12'h000, 0, 0));
    ctl.startn = 1'b1;
    cyc();

    // 2: 1:55 countdown, minute borrow, clear
    press(1); press(5); press(5);
    chk("t2_digits", dut_time(), 16'h0155);
    start_pulse();
    repeat (24) cyc();
    chk("t2_6ticks", dut_time(), 16'h0149);
    repeat (196) cyc();
    chk("t2_1min", dut_time(), 16'h0100);
    repeat (4) cyc();
    chk("t2_borrow", dut_vec(), mk(1, 12'h059, 1, 0));
    ctl.clrn = 1'b0;
    cyc();
    ctl.clrn = 1'b1;
    chk("t2_clear", dut_vec(), mk(0, 12'h000, 0, 0));

    // 3: pause on door open, frozen prescaler, stop twice
    press(2); press(5); press(4);
    start_pulse();
    repeat (22) cyc();
    chk("t3_5ticks", dut_time(), 16'h0249);
    ctl.porta_fechada = 1'b0;
    cyc();
    chk("t3_pause", dut_vec(), mk(2, 12'h249, 0, 0));
    press(7);
    chk("t3_key_ignored", dut_vec(), mk(2, 12'h249, 0, 0));
    ctl.porta_fechada = 1'b1;
    cyc();
    start_pulse();
    chk("t3_resume", dut_vec(), mk(1, 12'h249, 1, 0));
    cyc();
    cyc();
    chk("t3_frozen_presc", dut_time(), 16'h0248);
    ctl.stopn = 1'b0;
    cyc();
    ctl.stopn = 1'b1;
    cyc();
    ctl.stopn = 1'b0;
    cyc();
    ctl.stopn = 1'b1;
    chk("t3_stop_idle", dut_vec(), mk(0, 12'h000, 0, 0));
    cyc();

    // 4: rejected keys, start with door open
    press(7);
    press(9);
    chk("t4_reject_gt5", dut_time(), 16'h0007);
    ctl.teclado = 10'b0000011000;
    cyc();
    ctl.teclado = 10'd0;
    cyc();
    chk("t4_multikey", dut_time(), 16'h0007);
    ctl.porta_fechada = 1'b0;
    start_pulse();
    chk("t4_door_open_start", dut_vec(), mk(0, 12'h007, 0, 0));
    ctl.porta_fechada = 1'b1;
    cyc();

    // 5: simultaneous events
    ctl.clrn = 1'b0;
    ctl.startn = 1'b0;
    cyc();
    chk("t5_clr_vs_start", dut_vec(), mk(0, 12'h000, 0, 0));
    ctl.clrn = 1'b1;
    ctl.startn = 1'b1;
    cyc();
    press(5);
    start_pulse();
    repeat (3) cyc();
    ctl.porta_fechada = 1'b0;
    cyc();
    chk("t5_door_vs_tick", dut_vec(), mk(2, 12'h005, 0, 0));
    ctl.porta_fechada = 1'b1;
    cyc();
    start_pulse();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_rst_cook", dut_vec(), 16'h0000);

    // 6: quick start
`ifdef QUICK_START_EN
    start_pulse();
    chk("t6_quick", dut_vec(), mk(1, 12'h030, 1, 0));
    repeat (8) cyc();
    chk("t6_028", dut_time(), 16'h0028);
    start_pulse();
    chk("t6_add30", dut_time(), 16'h0058);
    ctl.clrn = 1'b0;
    cyc();
    ctl.clrn = 1'b1;
    press(5); press(5); press(0);
    start_pulse();
    for (int i = 0; i < 8; i++) begin
      start_pulse();
      cyc();
    end
    chk("t6_948", dut_time(), 16'h0948);
    start_pulse();
    chk("t6_saturate", dut_time(), 16'h0959);
`else
    start_pulse();
    chk("t6_zero_start", dut_vec(), mk(0, 12'h000, 0, 0));
`endif
    ctl.clrn = 1'b0;
    cyc();
    ctl.clrn = 1'b1;
    cyc();

    // Random panel activity against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20) ctl.teclado = 10'(1 << $urandom_range(0, 9));
      else if (r < 23) ctl.teclado = 10'($urandom & 32'h3ff);
      else ctl.teclado = 10'd0;
      ctl.startn = ($urandom_range(0, 99) < 15) ? 1'b0 : 1'b1;
      ctl.stopn = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      ctl.clrn = ($urandom_range(0, 199) < 2) ? 1'b0 : 1'b1;
      ctl.porta_fechada = ($urandom_range(0, 99) < 5) ? 1'b0 : 1'b1;
      rst = ($urandom_range(0, 999) < 2) ? 1'b1 : 1'b0;
      cyc();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
